// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream record decoder that loads the 4-bit CPU program RAM
module program_loader #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       input_mode,
    output logic [3:0] input_address,
    output logic [7:0] input_program,
    output logic       prog_we,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] write_count,
    output logic       cpu_run
);

    localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);
    localparam logic [3:0] CMD_WRITE = 4'h0;
    localparam logic [3:0] CMD_END   = 4'hF;
    localparam logic [4:0] COUNT_MAX = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] hold_cnt;
    logic       xfer;
    logic       hold_last;
    logic       session_start;
    logic       in_session;
    logic [3:0] cmd;

    always_comb begin
        state_nxt     = state;
        cmd           = rx_data[7:4];
        in_session    = (state == S_HDR) || (state == S_DATA) || (state == S_WRITE);
        rx_ready      = (state == S_HDR) || (state == S_DATA);
        xfer          = rx_valid && rx_ready;
        hold_last     = (hold_cnt == HOLD_LAST);
        // start only opens a session from a resting state; mid-session pulses are dropped
        session_start = start && !in_session;
        input_mode    = in_session;
        busy          = in_session;
        prog_we       = (state == S_WRITE);

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_HDR;
            end
            S_HDR: begin
                if (xfer) begin
                    if (cmd == CMD_WRITE)    state_nxt = S_DATA;
                    else if (cmd == CMD_END) state_nxt = S_DONE;
                    else                     state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (hold_last) state_nxt = S_HDR;
            end
            S_DONE, S_ERR: begin
                if (start) state_nxt = S_HDR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            hold_cnt      <= 3'd0;
            input_address <= 4'd0;
            input_program <= 8'd0;
            done          <= 1'b0;
            error         <= 1'b0;
            write_count   <= 5'd0;
        end else begin
            state <= state_nxt;

            if (session_start) begin
                done        <= 1'b0;
                error       <= 1'b0;
                write_count <= 5'd0;
            end

            if (state == S_HDR && xfer) begin
                if (cmd == CMD_WRITE)    input_address <= rx_data[3:0];
                else if (cmd == CMD_END) done          <= 1'b1;
                else                     error         <= 1'b1;
            end

            if (state == S_DATA && xfer) begin
                input_program <= rx_data;
                hold_cnt      <= 3'd0;
            end

            // address and data registers are untouched while the pair is held
            if (state == S_WRITE) begin
                hold_cnt <= hold_cnt + 3'd1;
                if (hold_last && write_count != COUNT_MAX)
                    write_count <= write_count + 5'd1;
            end
        end
    end

    assign cpu_run = done;

endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for the 4-bit CPU's program RAM: accepts a byte stream over a valid/ready handshake, decodes address/data records, and drives the RAM load port (`input_mode`, `input_address`, `input_program`). It holds the RAM in load mode until an end record arrives, then releases it and signals the sequencer that execution may begin. It replaces hand-driven loading of program and data bytes (e.g. data at 9h/Ah, code from 0h) with a repeatable hardware path.

## Interface
- `HOLD_CYCLES`, default 2: cycles each address/data pair is held stable on the RAM load port, with `prog_we` high (1..7).

- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load session.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader can accept a byte.
- `input_mode` out 1: RAM load-mode select; high for the whole session.
- `input_address` out 4: RAM load address.
- `input_program` out 8: RAM load data.
- `prog_we` out 1: high while a pair is being held.
- `busy` out 1: session in progress.
- `done` out 1: session ended cleanly; sticky.
- `error` out 1: malformed record; sticky.
- `write_count` out 5: records written this session (0..16, saturating).
- `cpu_run` out 1: equals `done`; gates the CPU sequencer.

## Operation
- **Record format:**
  - Header byte `{cmd[7:4], addr[3:0]}`.
  - `cmd` 4'h0 = write; the next byte is the data for `addr`.
  - `cmd` 4'hF = end of session; `addr` is ignored.
  - Any other `cmd` is an error.
- **States:** IDLE, HDR, DATA, WRITE, DONE, ERR.
- **IDLE:** `start` → HDR.
- **HDR:**
  - `rx_ready`=1.
  - On transfer with `cmd`=0: latch `addr` → DATA.
  - `cmd`=F → DONE.
  - Any other `cmd` → ERR.
- **DATA:** `rx_ready`=1; on transfer latch the byte into `input_program` → WRITE.
- **WRITE:**
  - `prog_we`=1 for exactly `HOLD_CYCLES` cycles; address and data do not change during the hold.
  - Then `write_count` += 1 (saturating at 16) → HDR.
- **DONE / ERR:**
  - Terminal states; `input_mode`=0.
  - `start` re-enters HDR, clearing `done`, `error` and `write_count` on the same edge.
- **Duplicate addresses** are allowed; the last write wins and each one still counts.
- `start` is ignored in HDR, DATA and WRITE.
- A transfer occurs only on a cycle where `rx_valid` and `rx_ready` are both 1. `rx_data` is don't-care otherwise.

## Timing
- **Reset values (one edge after `reset`=1):**
  - State = IDLE.
  - `rx_ready`, `input_mode`, `prog_we`, `busy`, `done`, `error`, `cpu_run` = 0.
  - `input_address` = 0, `input_program` = 0, `write_count` = 0.
- **`reset` mid-session:** outputs return to reset values on that edge. `input_mode` drops with no further `prog_we`. Partially received records are discarded.
- **`reset` has priority** over `start` and over a transfer on the same edge.
- **Session entry:** `start` sampled at edge N → `input_mode`=1, `busy`=1, `rx_ready`=1 from N+1.
- **`input_mode` timing:**
  - Rises one cycle before the first `prog_we`, at the latest.
  - Falls on the same edge that `done` or `error` rises.
- **Header stage:** header transfer at edge M → DATA from M+1. `input_address` updates at M and is stable from then on.
- **Data stage:**
  - Data transfer at edge D → `prog_we`=1 on cycles D+1 .. D+`HOLD_CYCLES`.
  - `rx_ready`=0 during the hold.
  - `rx_ready`=1 again at D+`HOLD_CYCLES`+1.
- **Throughput:** with `rx_valid` held at 1, one record takes 2+`HOLD_CYCLES` cycles.
- **End record:** transfer at edge E → `done`=`cpu_run`=1, `busy`=0, `input_mode`=0 from E+1.
- **Backpressure:** `rx_valid` may drop at any cycle; the loader waits indefinitely in HDR/DATA. There is no timeout.

## Test plan
- **Nominal load** (`HOLD_CYCLES`=2): stream 09 01, 0A 08, 00 79, 01 30, F0 → RAM[9]=01, RAM[A]=08, RAM[0]=79, RAM[1]=30. `write_count`=4, `done`=1. `input_mode` falls the cycle after F0 is accepted.
- **Backpressure:** toggle `rx_valid` randomly over the same stream → identical RAM contents. No transfer occurs while `rx_ready`=0. `prog_we` is exactly 2 cycles per record.
- **Bad command:** 05 11, 3C → `error`=1 after 3C, `input_mode`=0, `write_count`=1. A subsequent `start` followed by F0 gives `done`=1, `error`=0, `write_count`=0.
- **Saturation/duplicates:** 18 writes (two of them to address 3, last data 5A), then F0 → `write_count`=16 and RAM[3]=5A.
- **Reset mid-hold:** assert `reset` during the first `prog_we` cycle → next edge all outputs at reset values. No further `prog_we`. `rx_ready`=0 until the next `start`.
- **Start in session:** pulse `start` while in DATA → ignored; the record completes normally.
